map_142_core: RTL

- Register file, PRG banking and IRQ engine for Kaiser KS7032 (mapper 142) boards.
- Sits directly under the per-mapper output mux. It consumes the synchronised CPU write strobes and M2 ticks that come from the system bus.
- It produces the PRG bank, PRG select and IRQ signals that the map_142 wrapper packs into map_out.
- CHR is 8 KB CHR-RAM, unbanked, and is not handled here.

---
 rtl/map_142_core.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/map_142_core.sv
// map_142_core: KS7032 (mapper 142) registers, PRG banking, IRQ counter.
// Ports: clk, rst (async, active-high), cpu_addr/cpu_dat/cpu_wr_stb
//   (CPU writes), m2_tick (M2 cycle pulse), prg_bank/prg_ce (PRG map),
//   irq (active-high request), ss_addr/ss_dout (save-state readback).
// Optional: define MAP142_SS_EN to build the save-state readback mux;
//   otherwise ss_dout is tied to zero.
module map_142_core #(
  parameter int PRG_BW = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       cpu_addr,
  input  logic [7:0]        cpu_dat,
  input  logic              cpu_wr_stb,
  input  logic              m2_tick,
  output logic [PRG_BW-1:0] prg_bank,
  output logic              prg_ce,
  output logic              irq,
  input  logic [3:0]        ss_addr,
  output logic [7:0]        ss_dout
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   latch;
  logic [CNT_W-1:0]   counter;
  logic [2:0]         sel;
  logic [PRG_BW-1:0]  bank1;
  logic [PRG_BW-1:0]  bank2;
  logic [PRG_BW-1:0]  bank3;
  logic [PRG_BW-1:0]  bank4;

  logic       irq_en;
  logic       wr;
  logic [2:0] reg_idx;
  logic       ovf;

  assign irq_en  = (state == RUN);
  assign wr      = cpu_wr_stb & cpu_addr[15];
  assign reg_idx = cpu_addr[14:12];
  assign ovf     = m2_tick & irq_en & (counter == '1);

  logic unused;
  assign unused = ^{cpu_addr[11:0], cpu_dat};

  // Tick handling first; a write later in the block overrides it
  // ($C000 wins over a tick; an ack loses to a same-clk overflow).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      latch   <= '0;
      counter <= '0;
      irq     <= 1'b0;
      sel     <= '0;
      bank1   <= '0;
      bank2   <= '0;
      bank3   <= '0;
      bank4   <= '0;
    end else begin
      if (m2_tick && state == RUN) begin
        if (ovf) begin
          counter <= latch;
          irq     <= 1'b1;
        end else begin
          counter <= counter + CNT_W'(1);
        end
      end
      if (wr) begin
        unique case (reg_idx)
          3'd0: latch[3:0]   <= cpu_dat[3:0];
          3'd1: latch[7:4]   <= cpu_dat[3:0];
          3'd2: latch[11:8]  <= cpu_dat[3:0];
          3'd3: latch[15:12] <= cpu_dat[3:0];
          3'd4: begin
            irq <= 1'b0;
            if (cpu_dat[1]) begin
              state   <= RUN;
              counter <= latch;
            end else begin
              state   <= IDLE;
              counter <= counter;
            end
          end
          3'd5: begin
            if (!ovf) irq <= 1'b0;
          end
          3'd6: sel <= cpu_dat[2:0];
          3'd7: begin
            case (sel)
              3'd1:    bank1 <= cpu_dat[PRG_BW-1:0];
              3'd2:    bank2 <= cpu_dat[PRG_BW-1:0];
              3'd3:    bank3 <= cpu_dat[PRG_BW-1:0];
              3'd4:    bank4 <= cpu_dat[PRG_BW-1:0];
              default: ;
            endcase
          end
        endcase
      end
    end
  end

  assign prg_ce = cpu_addr[15] | (cpu_addr[14] & cpu_addr[13]);

  always_comb begin
    prg_bank = '0;
    case (cpu_addr[15:13])
      3'b011:  prg_bank = bank4;
      3'b100:  prg_bank = bank1;
      3'b101:  prg_bank = bank2;
      3'b110:  prg_bank = bank3;
      3'b111:  prg_bank = '1;
      default: prg_bank = '0;
    endcase
  end

`ifdef MAP142_SS_EN
  always_comb begin
    ss_dout = '0;
    case (ss_addr)
      4'd0:    ss_dout = {4'b0, latch[3:0]};
      4'd1:    ss_dout = {4'b0, latch[7:4]};
      4'd2:    ss_dout = {4'b0, latch[11:8]};
      4'd3:    ss_dout = {4'b0, latch[15:12]};
      4'd4:    ss_dout = counter[7:0];
      4'd5:    ss_dout = counter[15:8];
      4'd6:    ss_dout = {irq, irq_en, 3'b0, sel};
      4'd7:    ss_dout = 8'(bank1);
      4'd8:    ss_dout = 8'(bank2);
      4'd9:    ss_dout = 8'(bank3);
      4'd10:   ss_dout = 8'(bank4);
      default: ss_dout = '0;
    endcase
  end
`else
  logic unused_ss;
  assign unused_ss = ^ss_addr;
  assign ss_dout   = '0;
`endif

endmodule
